netlist_eq_sim: RTL and testbench
=================================

NETLIST_EQ_SIM -- requirements
Module: netlist_eq_sim

Interface
REQ-001 Parameter N_IN, default 14, width of the primary-input pattern driven to both netlists.
REQ-002 Parameter N_OUT, default 8, width of each netlist response.
REQ-003 Parameter LFSR_POLY, default 14'h2B, Galois feedback taps for the N_IN-bit pattern LFSR.
REQ-004 Parameter SIG_W, default 32, MISR signature width; SIG_W >= N_OUT.
REQ-005 Parameter SIG_POLY, default 32'h04C11DB7, MISR feedback taps.
REQ-006 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-007 clk  input  1  rising-edge clock.
REQ-008 rst_n  input  1  asynchronous active-low reset.
REQ-009 start  input  1  single-cycle pulse that begins a run; sampled only in IDLE or DONE.
REQ-010 seed  input  N_IN  LFSR seed, captured on start.
REQ-011 num_pat  input  16  number of patterns in the run, captured on start.
REQ-012 pat_out  output  N_IN  current pattern to both netlists.
REQ-013 pat_valid  output  1  pat_out is valid.
REQ-014 pat_ready  input  1  consumer accepts pat_out this cycle.
REQ-015 resp_valid  input  1  golden_resp/cand_resp valid this cycle, returned in pattern order.
REQ-016 golden_resp, cand_resp  input  N_OUT  responses of reference and candidate netlists.
REQ-017 busy  output  1  high in RUN or DRAIN.
REQ-018 done  output  1  high in DONE.
REQ-019 equal  output  1  no mismatch in the last run; valid while done.
REQ-020 mismatch_cnt  output  16  mismatching responses, saturating at 16'hFFFF.
REQ-021 first_fail  output  16  index (0-based) of first mismatching response; 16'hFFFF if none.
REQ-022 sig_golden, sig_cand  output  SIG_W  MISR signatures of each response stream.

Function
REQ-023 States IDLE, RUN, DRAIN, DONE; IDLE->RUN on start with num_pat>0; IDLE->DONE on start with num_pat==0.
REQ-024 On accepted start: LFSR loaded with seed (all-zero seed replaced by 1), issue and response counters, mismatch_cnt, MISRs cleared to 0, first_fail set to 16'hFFFF.
REQ-025 RUN: pat_valid=1; pat_out holds until pat_valid&pat_ready; on handshake LFSR advances one Galois step and issue count increments.
REQ-026 RUN->DRAIN in the cycle the num_pat-th pattern handshakes; pat_valid=0 from the next cycle.
REQ-027 Responses accepted in RUN and DRAIN; resp_valid in IDLE or DONE ignored; responses beyond num_pat ignored.
REQ-028 Per accepted response: each MISR = (shift-left-one with SIG_POLY feedback on MSB) XOR zero-extended response.
REQ-029 Per accepted response with golden_resp != cand_resp: mismatch_cnt increments (saturating); first_fail captured if still 16'hFFFF.
REQ-030 ->DONE in the cycle after the num_pat-th response is accepted (may occur from RUN if responses are zero-latency); results registered one cycle after that response.
REQ-031 equal = (mismatch_cnt==0); signatures reported but not used for equal.
REQ-032 Response arriving the same cycle as the final pattern handshake is counted normally.
REQ-033 start ignored while busy; start in DONE begins a new run (DONE->RUN/DONE).
REQ-034 Results hold in DONE until next accepted start.
REQ-035 Throughput one pattern per cycle with pat_ready held high; no combinational path from inputs to pat_valid.

Reset
REQ-036 rst_n low asynchronously forces IDLE: pat_valid=0, busy=0, done=0, equal=0, mismatch_cnt=0, first_fail=16'hFFFF, pat_out=0, signatures=0.
REQ-037 Reset mid-run abandons the run; responses after reset release are ignored until a new start.

Verification
REQ-038 seed=1, num_pat=4, pat_ready=1, cand==golden loopback zero latency -> 4 handshakes, done 1 cycle after 4th response, equal=1, mismatch_cnt=0, first_fail=FFFF, sig_golden==sig_cand.
REQ-039 Same, cand_resp bit0 flipped on response index 2 only -> mismatch_cnt=1, first_fail=2, equal=0, signatures differ.
REQ-040 num_pat=0 start -> DONE next cycle, pat_valid never 1, equal=1.
REQ-041 pat_ready toggling 1/0, 3-cycle response latency, num_pat=5 -> pat_out stable while stalled, exactly 5 handshakes, DRAIN until 5th response, then DONE.
REQ-042 seed=0 -> first pat_out=1; start pulse during RUN -> ignored; rst_n low mid-RUN -> all outputs at reset values immediately.

Source files
------------

// File: rtl/netlist_eq_sim_if.sv
// rtl/netlist_eq_sim_if.sv - pattern/response stream bundle between the checker and the two netlists
`timescale 1ns/1ps

interface netlist_eq_sim_if #(
  parameter int N_IN  = 14,
  parameter int N_OUT = 8
) ();
  logic [N_IN-1:0]  pat_out;
  logic             pat_valid;
  logic             pat_ready;
  logic             resp_valid;
  logic [N_OUT-1:0] golden_resp;
  logic [N_OUT-1:0] cand_resp;

  modport master (
    output pat_out,
    output pat_valid,
    input  pat_ready,
    input  resp_valid,
    input  golden_resp,
    input  cand_resp
  );

  modport slave (
    input  pat_out,
    input  pat_valid,
    output pat_ready,
    output resp_valid,
    output golden_resp,
    output cand_resp
  );
endinterface

// File: rtl/netlist_eq_sim.sv
// rtl/netlist_eq_sim.sv - LFSR-driven equivalence simulator comparing golden and candidate netlist responses
`timescale 1ns/1ps

module netlist_eq_sim #(
  parameter int              N_IN      = 14,
  parameter int              N_OUT     = 8,
  parameter logic [N_IN-1:0] LFSR_POLY = 14'h2B,
  parameter int              SIG_W     = 32,
  parameter logic [SIG_W-1:0] SIG_POLY = 32'h04C11DB7
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [N_IN-1:0]      seed,
  input  logic [15:0]          num_pat,
  netlist_eq_sim_if.master     bus,
  output logic                 busy,
  output logic                 done,
  output logic                 equal,
  output logic [15:0]          mismatch_cnt,
  output logic [15:0]          first_fail,
  output logic [SIG_W-1:0]     sig_golden,
  output logic [SIG_W-1:0]     sig_cand
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [N_IN-1:0]   lfsr;
  logic [15:0]       issue_cnt;
  logic [15:0]       resp_cnt;
  logic [15:0]       num_pat_r;

  logic start_ok;
  logic pat_hs;
  logic resp_acc;
  logic last_pat;
  logic last_resp;

  function automatic logic [N_IN-1:0] lfsr_step(input logic [N_IN-1:0] s);
    return {s[N_IN-2:0], 1'b0} ^ (s[N_IN-1] ? LFSR_POLY : '0);
  endfunction

  function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] s,
                                                 input logic [N_OUT-1:0] r);
    return ({s[SIG_W-2:0], 1'b0} ^ (s[SIG_W-1] ? SIG_POLY : '0)) ^ SIG_W'(r);
  endfunction

  assign start_ok  = start && ((state == IDLE) || (state == DONE));
  assign pat_hs    = (state == RUN) && bus.pat_ready;
  // Responses past the requested count are dropped even if the consumer keeps sending.
  assign resp_acc  = bus.resp_valid && ((state == RUN) || (state == DRAIN)) &&
                     (resp_cnt < num_pat_r);
  assign last_pat  = pat_hs && (issue_cnt == num_pat_r - 16'd1);
  assign last_resp = resp_acc && (resp_cnt == num_pat_r - 16'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt = (num_pat == 16'd0) ? DONE : RUN;
        end
      end
      RUN: begin
        // Zero-latency consumers can finish responses in the same cycle as the last pattern.
        if (last_resp) begin
          state_nxt = DONE;
        end else if (last_pat) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (last_resp) begin
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.pat_valid = (state == RUN);
    busy          = (state == RUN) || (state == DRAIN);
    done          = (state == DONE);
    equal         = (state == DONE) && (mismatch_cnt == 16'd0);
  end

  assign bus.pat_out = lfsr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr         <= '0;
      issue_cnt    <= 16'd0;
      resp_cnt     <= 16'd0;
      num_pat_r    <= 16'd0;
      mismatch_cnt <= 16'd0;
      first_fail   <= 16'hFFFF;
      sig_golden   <= '0;
      sig_cand     <= '0;
    end else if (start_ok) begin
      lfsr         <= (seed == '0) ? N_IN'(1) : seed;
      issue_cnt    <= 16'd0;
      resp_cnt     <= 16'd0;
      num_pat_r    <= num_pat;
      mismatch_cnt <= 16'd0;
      first_fail   <= 16'hFFFF;
      sig_golden   <= '0;
      sig_cand     <= '0;
    end else begin
      if (pat_hs) begin
        lfsr      <= lfsr_step(lfsr);
        issue_cnt <= issue_cnt + 16'd1;
      end
      if (resp_acc) begin
        resp_cnt   <= resp_cnt + 16'd1;
        sig_golden <= misr_step(sig_golden, bus.golden_resp);
        sig_cand   <= misr_step(sig_cand, bus.cand_resp);
        if (bus.golden_resp != bus.cand_resp) begin
          if (mismatch_cnt != 16'hFFFF) begin
            mismatch_cnt <= mismatch_cnt + 16'd1;
          end
          if (first_fail == 16'hFFFF) begin
            first_fail <= resp_cnt;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_netlist_eq_sim.sv
// tb/tb_netlist_eq_sim.sv - directed scoreboard bench for netlist_eq_sim
`timescale 1ns/1ps

module tb_netlist_eq_sim;

  localparam int N_IN  = 14;
  localparam int N_OUT = 8;
  localparam int SIG_W = 32;

  typedef struct packed {
    logic [15:0] mm;
    logic [15:0] ff;
    logic [31:0] sg;
    logic [31:0] sc;
    logic        eq;
    logic [15:0] n;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [13:0] seed = '0;
  logic [15:0] num_pat = '0;
  logic        busy, done, equal;
  logic [15:0] mismatch_cnt, first_fail;
  logic [31:0] sig_golden, sig_cand;

  int n_tests = 0;
  int n_fail  = 0;

  netlist_eq_sim_if #(.N_IN(N_IN), .N_OUT(N_OUT)) bus ();

  netlist_eq_sim #(
    .N_IN(N_IN), .N_OUT(N_OUT), .LFSR_POLY(14'h2B),
    .SIG_W(SIG_W), .SIG_POLY(32'h04C11DB7)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .seed(seed), .num_pat(num_pat),
    .bus(bus), .busy(busy), .done(done), .equal(equal),
    .mismatch_cnt(mismatch_cnt), .first_fail(first_fail),
    .sig_golden(sig_golden), .sig_cand(sig_cand)
  );

  always #5 clk = ~clk;

  function automatic logic [13:0] lfsr_next(input logic [13:0] s);
    return {s[12:0], 1'b0} ^ (s[13] ? 14'h2B : 14'h0);
  endfunction

  function automatic logic [31:0] misr_step(input logic [31:0] s, input logic [7:0] r);
    return ({s[30:0], 1'b0} ^ (s[31] ? 32'h04C11DB7 : 32'h0)) ^ {24'h0, r};
  endfunction

  function automatic logic [7:0] gold_fn(input logic [13:0] p);
    return p[7:0] ^ {2'b00, p[13:8]} ^ 8'hA5;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // Netlist model: zero-latency loopback or a 3-deep response delay line.
  int          lat_mode = 0;
  int          flip_idx = -1;
  int          resp_idx = 0;
  int          run_id   = 0;
  int          rid_seen = 0;
  logic        resp_force = 1'b0;
  logic [7:0]  cand_xor = 8'h00;
  logic        ready = 1'b1;
  logic [2:0]  dl_v = 3'b000;
  logic [13:0] dl_p [3];
  logic        resp_src_v;
  logic [13:0] resp_src_p;

  assign resp_src_v      = (lat_mode != 0) ? dl_v[2] : (bus.pat_valid & bus.pat_ready);
  assign resp_src_p      = (lat_mode != 0) ? dl_p[2] : bus.pat_out;
  assign bus.pat_ready   = ready;
  assign bus.resp_valid  = resp_src_v | resp_force;
  assign bus.golden_resp = gold_fn(resp_src_p);
  assign bus.cand_resp   = gold_fn(resp_src_p) ^ ((resp_idx == flip_idx) ? 8'h01 : 8'h00) ^ cand_xor;

  always @(posedge clk) begin
    dl_v    <= {dl_v[1:0], bus.pat_valid & bus.pat_ready};
    dl_p[0] <= bus.pat_out;
    dl_p[1] <= dl_p[0];
    dl_p[2] <= dl_p[1];
    if (rid_seen != run_id) begin
      rid_seen <= run_id;
      resp_idx <= 0;
    end else if (resp_src_v) begin
      resp_idx <= resp_idx + 1;
    end
  end

  logic [13:0] pat_q [$];
  res_t        res_q [$];
  int          exp_num = 0;
  bit          tog = 1'b0;

  int          hs_cnt = 0;
  int          resp_seen = 0;
  int          mon_id = 0;
  bit          active = 1'b0;
  bit          final_pend = 1'b0;
  bit          stall_pend = 1'b0;
  bit          pv_seen = 1'b0;
  bit          drain_seen = 1'b0;
  logic [13:0] stall_val = '0;

  initial begin
    forever begin
      @(negedge clk);
      if (mon_id != run_id) begin
        mon_id = run_id; hs_cnt = 0; resp_seen = 0; active = 1'b1;
        pv_seen = 1'b0; drain_seen = 1'b0; stall_pend = 1'b0; final_pend = 1'b0;
      end
      if (!rst_n) begin
        active = 1'b0; stall_pend = 1'b0; final_pend = 1'b0;
      end
      if (final_pend) begin
        check("done_after_last", done, 1);
        final_pend = 1'b0;
      end
      if (bus.pat_valid) pv_seen = 1'b1;
      if (busy && !bus.pat_valid) drain_seen = 1'b1;
      if (stall_pend && bus.pat_valid) check("pat_stable", bus.pat_out, stall_val);
      stall_pend = 1'b0;
      if (bus.pat_valid && !bus.pat_ready) begin
        stall_pend = 1'b1;
        stall_val  = bus.pat_out;
      end
      if (bus.pat_valid && bus.pat_ready) begin
        hs_cnt++;
        check("pat_q_has_entry", pat_q.size() != 0, 1);
        if (pat_q.size() != 0) check("pat_out", bus.pat_out, pat_q.pop_front());
      end
      if (active && bus.resp_valid && resp_seen < exp_num) begin
        resp_seen++;
        if (resp_seen == exp_num) begin
          check("done_not_early", done, 0);
          final_pend = 1'b1;
          active = 1'b0;
        end
      end
    end
  end

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      if (tog) ready = ~ready;
    end
  endtask

  task automatic start_run(input logic [13:0] s, input logic [15:0] n,
                           input int lat, input int flip, input bit tg);
    res_t        r;
    logic [13:0] p;
    logic [7:0]  g, c;
    lat_mode = lat; flip_idx = flip; tog = tg; ready = 1'b1;
    p = (s == 14'd0) ? 14'd1 : s;
    r.mm = 16'd0; r.ff = 16'hFFFF; r.sg = 32'd0; r.sc = 32'd0; r.n = n;
    for (int i = 0; i < int'(n); i++) begin
      pat_q.push_back(p);
      g = gold_fn(p);
      c = g ^ ((i == flip) ? 8'h01 : 8'h00);
      r.sg = misr_step(r.sg, g);
      r.sc = misr_step(r.sc, c);
      if (g != c) begin
        if (r.mm != 16'hFFFF) r.mm = r.mm + 16'd1;
        if (r.ff == 16'hFFFF) r.ff = 16'(i);
      end
      p = lfsr_next(p);
    end
    r.eq = (r.mm == 16'd0);
    res_q.push_back(r);
    exp_num = int'(n);
    @(posedge clk); #1;
    seed = s; num_pat = n; start = 1'b1; run_id++;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic finish_run(input string tag);
    res_t r;
    for (int k = 0; k < 300; k++) begin
      if (done) break;
      @(posedge clk); #1;
      if (tog) ready = ~ready;
    end
    check({tag, "_done"}, done, 1);
    check({tag, "_res_q"}, res_q.size() != 0, 1);
    if (res_q.size() != 0) begin
      r = res_q.pop_front();
      check({tag, "_mismatch_cnt"}, mismatch_cnt, r.mm);
      check({tag, "_first_fail"}, first_fail, r.ff);
      check({tag, "_sig_golden"}, sig_golden, r.sg);
      check({tag, "_sig_cand"}, sig_cand, r.sc);
      check({tag, "_equal"}, equal, r.eq);
      check({tag, "_handshakes"}, hs_cnt, r.n);
    end
    check({tag, "_pat_valid_low"}, bus.pat_valid, 0);
    tog = 1'b0; ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_pat_valid"}, bus.pat_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_equal"}, equal, 0);
    check({tag, "_mismatch_cnt"}, mismatch_cnt, 0);
    check({tag, "_first_fail"}, first_fail, 16'hFFFF);
    check({tag, "_pat_out"}, bus.pat_out, 0);
    check({tag, "_sig_golden"}, sig_golden, 0);
    check({tag, "_sig_cand"}, sig_cand, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: observed no finish required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst_n = 1'b1;
    step(2);

    // Loopback, matching netlists.
    start_run(14'd1, 16'd4, 0, -1, 1'b0);
    finish_run("eq4");

    // Single mismatch on response 2; also a restart from DONE.
    start_run(14'd1, 16'd4, 0, 2, 1'b0);
    finish_run("flip2");

    // Empty run.
    start_run(14'h155, 16'd0, 0, -1, 1'b0);
    check("np0_done_next", done, 1);
    check("np0_equal", equal, 1);
    step(3);
    check("np0_pv_never", pv_seen, 0);
    finish_run("np0");

    // Stalled consumer with delayed responses.
    start_run(14'h1A5, 16'd5, 3, -1, 1'b1);
    finish_run("lat3");
    check("lat3_drain_seen", drain_seen, 1);

    // Zero seed and a start pulse while busy.
    start_run(14'd0, 16'd6, 0, -1, 1'b1);
    check("seed0_first", bus.pat_out, 1);
    step(3);
    seed = 14'd5; num_pat = 16'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("start_ignored_busy", busy, 1);
    finish_run("seed0");

    // Reset in the middle of a run.
    start_run(14'd3, 16'd10, 3, 0, 1'b0);
    step(6);
    check("pre_reset_busy", busy, 1);
    check("pre_reset_mm", mismatch_cnt, 1);
    rst_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    pat_q.delete();
    res_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(1);
    resp_force = 1'b1; cand_xor = 8'hFF;
    step(1);
    resp_force = 1'b0; cand_xor = 8'h00;
    step(4);
    check("post_rst_mm", mismatch_cnt, 0);
    check("post_rst_ff", first_fail, 16'hFFFF);
    check("post_rst_sig_golden", sig_golden, 0);
    check("post_rst_sig_cand", sig_cand, 0);
    check("post_rst_busy", busy, 0);
    check("post_rst_done", done, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
